pulse_prescaler: RTL and testbench
==================================

Name: pulse_prescaler

Overview:
Runtime-programmable successor to the fixed-ratio pulse divider for the frequency counter front end. It resamples an external pulse/clock-like signal into the system clock domain and detects rising edges. It divides the edge rate by a ratio N chosen at runtime in 1..2^DIV_W. Outputs are a one-cycle strobe per N input edges and a toggling square output for the gate/counter logic downstream.

Parameters:
DIV_W, 8, width of the divisor field; ratio N = div_value + 1, so N ranges over 1..2^DIV_W
DEFAULT_RATIO, 2, ratio N in force after reset; legal range 1..2^DIV_W
SYNC_STAGES, 2, number of synchroniser flops on sig_in; minimum 2

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  reset, synchronous, active-high
sig_in  in  1  asynchronous input signal to divide
enable  in  1  1 = count edges; 0 = ignore edges and hold the counter
div_value  in  DIV_W  new ratio minus one
div_load  in  1  one-cycle request to adopt div_value
div_ack  out  1  one-cycle pulse when the requested ratio becomes active
pulse_out  out  1  one-cycle strobe on every Nth detected rising edge
square_out  out  1  toggles on every strobe; frequency is f_in/(2N)
div_active  out  DIV_W  currently active div_value, for readback

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - synchroniser flops and edge-detect history to 0
  - pulse_out=0, square_out=0, div_ack=0
  - div_active=DEFAULT_RATIO-1, cnt=DEFAULT_RATIO-1
  - pending flag cleared
- A reset mid-period discards the partial count and any pending load.
- Synchronisation and edge detection:
  - sig_in passes through SYNC_STAGES flops, then a history flop.
  - edge_stb = sync_last & ~hist.
  - Latency from the first sampling edge that sees sig_in high to pulse_out high is exactly SYNC_STAGES+1 cycles.
  - Input high and low times must each be at least 2 clk periods. Shorter pulses may be lost; this is not checked.
- Counting (down-counter cnt, DIV_W bits). On edge_stb with enable=1:
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0 (terminal): pulse_out <= 1 for the next cycle, square_out toggles, and cnt reloads with the ratio in force (see loads below).
  - The first strobe after reset or after a ratio change lands on the Nth edge, not the first.
- N=1 (div_value=0): every detected edge produces a strobe. Two edges in consecutive cycles are impossible given the input timing limit above.
- enable=0: edges are ignored, cnt holds, outputs other than div_ack stay at 0 or hold their value (square_out holds).
- Divisor loads:
  - div_load=1 stores div_value in a pending register and sets the pending flag. A second load before application overwrites it; the last value wins, and only one ack is issued.
  - When enable=1, pending is applied at the next terminal event: cnt reloads with the pending value, div_active updates, and div_ack=1 the following cycle.
  - When enable=0, pending is applied the cycle after it is captured, with cnt <= pending value; then div_ack.
  - div_load in the same cycle as a terminal event: that terminal event emits its strobe and the new value is applied at this boundary.
  - div_ack never asserts without a preceding div_load.
- All outputs are registered; there is no combinational path from any input to any output.

Decomposition:
- Shared package: PRESCALER_MIN_SYNC=2 constant and the helper that computes the reset counter value (DEFAULT_RATIO-1).
- Sub-module: pulse_sync_edge (SYNC_STAGES synchroniser plus rising-edge one-cycle strobe). It is reusable by the other frequency-counter inputs.
- The top level holds the counter, pending/shadow logic and output registers.

Test Plan:
- Reset then 10 edges with defaults (N=2, SYNC=2) -> pulse_out on edges 2,4,6,8,10, each 3 cycles after sampling. square_out ends at 1 after 5 toggles.
- Load div_value=4 mid-period (after edge 1 of a N=2 period) -> strobe still on edge 2. Next strobes on edges 7 and 12. div_ack one cycle after the edge-2 strobe cycle. div_active=4.
- div_value=0 with 6 edges -> 6 strobes, 6 square_out toggles.
- enable=0 for 3 edges between edges 1 and 2 (N=3) -> those edges are ignored and the strobe occurs on the third enabled edge. A div_load while disabled acks within 2 cycles.
- Two div_loads (5 then 1) before the boundary -> a single div_ack and div_active=1. div_load coincident with terminal: the strobe occurs and the new ratio is applied immediately.
- Assert rst for 1 cycle after 1 of 3 edges -> outputs 0 and div_active=DEFAULT_RATIO-1 next cycle. The next strobe comes on the 2nd post-reset edge.

Source files
------------

// File: rtl/pulse_prescaler_pkg.sv
// Shared constants and helpers for the pulse prescaler
// and the synchroniser front end it is built from.
package pulse_prescaler_pkg;

  localparam int PRESCALER_MIN_SYNC = 2;

  typedef enum logic [1:0] {
    APPLY_NONE,
    APPLY_TERM,
    APPLY_IDLE
  } apply_e;

  function automatic int unsigned reset_cnt(
    input int unsigned ratio
  );
    return (ratio == 0) ? 0 : ratio - 1;
  endfunction

endpackage

// File: rtl/pulse_prescaler_sync_edge.sv
// Synchroniser chain plus registered rising-edge strobe,
// shared by the frequency-counter input channels.
module pulse_sync_edge
  import pulse_prescaler_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic edge_stb
);

  localparam int NSYNC =
    (SYNC_STAGES < PRESCALER_MIN_SYNC) ?
    PRESCALER_MIN_SYNC : SYNC_STAGES;

  logic [NSYNC-1:0] sync;
  logic             hist;

  // Resample, keep one cycle of history, strobe on 0->1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      hist     <= 1'b0;
      edge_stb <= 1'b0;
    end else begin
      sync     <= {sync[NSYNC-2:0], sig_in};
      hist     <= sync[NSYNC-1];
      edge_stb <= sync[NSYNC-1] & ~hist;
    end
  end

endmodule

// File: rtl/pulse_prescaler.sv
// Runtime-programmable edge-rate divider: strobe every
// N detected rising edges plus a half-rate square output.
module pulse_prescaler
  import pulse_prescaler_pkg::*;
#(
  parameter int DIV_W         = 8,
  parameter int DEFAULT_RATIO = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_value,
  input  logic             div_load,
  output logic             div_ack,
  output logic             pulse_out,
  output logic             square_out,
  output logic [DIV_W-1:0] div_active
);

  localparam logic [DIV_W-1:0] RST_DIV =
    DIV_W'(reset_cnt(DEFAULT_RATIO));

  logic             edge_stb;
  logic             tick;
  logic             terminal;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] pend_val;
  logic [DIV_W-1:0] pend_nxt;
  logic             pend_flag;
  logic             pend_flag_nxt;
  logic [DIV_W-1:0] new_val;
  logic [DIV_W-1:0] active_nxt;
  logic             pulse_nxt;
  logic             square_nxt;
  logic             ack_nxt;
  apply_e           apply;

  pulse_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .sig_in  (sig_in),
    .edge_stb(edge_stb)
  );

  assign tick     = edge_stb & enable;
  assign terminal = tick & (cnt == '0);
  // A load in the applying cycle is newer than the shadow.
  assign new_val  = div_load ? div_value : pend_val;

  // Pick the boundary at which a requested ratio lands.
  always_comb begin
    apply = APPLY_NONE;
    unique case (1'b1)
      terminal: begin
        if (div_load | pend_flag)
          apply = APPLY_TERM;
      end
      !enable: begin
        if (pend_flag)
          apply = APPLY_IDLE;
      end
      default: apply = APPLY_NONE;
    endcase
  end

  // Counter, shadow register and output next-state.
  always_comb begin
    cnt_nxt       = cnt;
    pend_nxt      = pend_val;
    pend_flag_nxt = pend_flag;
    active_nxt    = div_active;
    pulse_nxt     = 1'b0;
    square_nxt    = square_out;
    ack_nxt       = 1'b0;

    if (div_load) begin
      pend_nxt      = div_value;
      pend_flag_nxt = 1'b1;
    end

    if (tick) begin
      cnt_nxt = terminal ?
        div_active : cnt - DIV_W'(1);
    end

    if (terminal) begin
      pulse_nxt  = 1'b1;
      square_nxt = ~square_out;
    end

    unique case (apply)
      APPLY_TERM, APPLY_IDLE: begin
        cnt_nxt       = new_val;
        active_nxt    = new_val;
        pend_flag_nxt = 1'b0;
        ack_nxt       = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= RST_DIV;
      div_active <= RST_DIV;
      pend_val   <= '0;
      pend_flag  <= 1'b0;
      pulse_out  <= 1'b0;
      square_out <= 1'b0;
      div_ack    <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      div_active <= active_nxt;
      pend_val   <= pend_nxt;
      pend_flag  <= pend_flag_nxt;
      pulse_out  <= pulse_nxt;
      square_out <= square_nxt;
      div_ack    <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_prescaler.sv
// Scoreboard bench for pulse_prescaler: directed plan
// followed by randomized edges, loads and enable changes.
module tb_pulse_prescaler;

  localparam int DIV_W = 8;
  localparam int DEF   = 2;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;
  logic             enable;
  logic [DIV_W-1:0] div_value;
  logic             div_load;
  logic             div_ack;
  logic             pulse_out;
  logic             square_out;
  logic [DIV_W-1:0] div_active;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_pulse = 0;
  int n_ack   = 0;

  pulse_prescaler #(
    .DIV_W(DIV_W),
    .DEFAULT_RATIO(DEF),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .enable    (enable),
    .div_value (div_value),
    .div_load  (div_load),
    .div_ack   (div_ack),
    .pulse_out (pulse_out),
    .square_out(square_out),
    .div_active(div_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; bit sq; } pexp_t;
  typedef struct { int c; int act; } aexp_t;
  pexp_t pq[$];
  aexp_t aq[$];

  // Reference model: edges seen in the current period
  // against the active ratio N = act + 1.
  int m_seen;
  int m_act;
  int m_pend;
  bit m_pv;
  bit m_sq;
  bit m_en;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic void m_reset();
    m_seen = 0;
    m_act  = DEF - 1;
    m_pv   = 0;
    m_sq   = 0;
    pq.delete();
    aq.delete();
  endfunction

  // c0: cycle count at the negedge where sig_in rose.
  function automatic void m_edge(int c0);
    if (!m_en) return;
    m_seen++;
    if (m_seen < m_act + 1) return;
    m_seen = 0;
    m_sq   = !m_sq;
    if (m_pv) begin
      m_act = m_pend;
      m_pv  = 0;
      aq.push_back('{c: c0 + 4, act: m_act});
    end
    pq.push_back('{c: c0 + 4, sq: m_sq});
  endfunction

  function automatic void m_load(int v, int c);
    if (m_en) begin
      m_pend = v;
      m_pv   = 1;
    end else begin
      m_act  = v;
      m_seen = 0;
      aq.push_back('{c: c + 2, act: v});
    end
  endfunction

  function automatic void m_disable(int c);
    m_en = 0;
    if (m_pv) begin
      m_pv   = 0;
      m_act  = m_pend;
      m_seen = 0;
      aq.push_back('{c: c + 1, act: m_act});
    end
  endfunction

  // Monitor: pop expectations when the DUT presents them.
  always @(negedge clk) begin
    while (pq.size() > 0 && pq[0].c < cyc) begin
      chk("pulse_missing", cyc, pq[0].c);
      void'(pq.pop_front());
    end
    while (aq.size() > 0 && aq[0].c < cyc) begin
      chk("ack_missing", cyc, aq[0].c);
      void'(aq.pop_front());
    end
    if (pulse_out) begin
      n_pulse++;
      if (pq.size() == 0) begin
        chk("pulse_unexpected", 1, 0);
      end else begin
        chk("pulse_cycle", cyc, pq[0].c);
        chk("square_out", int'(square_out), int'(pq[0].sq));
        void'(pq.pop_front());
      end
    end
    if (div_ack) begin
      n_ack++;
      if (aq.size() == 0) begin
        chk("ack_unexpected", 1, 0);
      end else begin
        chk("ack_cycle", cyc, aq[0].c);
        chk("ack_div_active", int'(div_active), aq[0].act);
        void'(aq.pop_front());
      end
    end
  end

  // One input pulse; optionally a load in its terminal cycle.
  task automatic do_edge(bit with_load, int v);
    int c0;
    int hi;
    int lo;
    hi = $urandom_range(2, 4);
    lo = $urandom_range(3, 5);
    c0 = cyc;
    sig_in = 1'b1;
    if (with_load) begin
      repeat (3) @(negedge clk);
      div_value = DIV_W'(v);
      div_load  = 1'b1;
      m_load(v, cyc);
      m_edge(c0);
      @(negedge clk);
      div_load = 1'b0;
    end else begin
      m_edge(c0);
      repeat (hi) @(negedge clk);
    end
    sig_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic edges(int n);
    for (int i = 0; i < n; i++) do_edge(0, 0);
  endtask

  task automatic load(int v);
    div_value = DIV_W'(v);
    div_load  = 1'b1;
    m_load(v, cyc);
    @(negedge clk);
    div_load = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_en(bit e);
    enable = e;
    if (!e) m_disable(cyc);
    else m_en = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_pulse(int n);
    rst = 1'b1;
    sig_in = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    m_reset();
    chk("rst_pulse_out", int'(pulse_out), 0);
    chk("rst_square_out", int'(square_out), 0);
    chk("rst_div_ack", int'(div_ack), 0);
    chk("rst_div_active", int'(div_active), DEF - 1);
  endtask

  int p0;
  int a0;

  initial begin
    rst       = 1'b1;
    sig_in    = 1'b0;
    enable    = 1'b1;
    div_value = '0;
    div_load  = 1'b0;
    m_en      = 1;
    m_reset();
    @(negedge clk);
    reset_pulse(3);

    // Defaults: N=2 over 10 edges.
    p0 = n_pulse;
    edges(10);
    chk("n2_pulses", n_pulse - p0, 5);
    chk("n2_square", int'(square_out), 1);

    // Load 4 after edge 1 of an N=2 period.
    p0 = n_pulse;
    edges(1);
    load(4);
    edges(1);
    chk("ld4_strobe_edge2", n_pulse - p0, 1);
    chk("ld4_active", int'(div_active), 4);
    edges(4);
    chk("ld4_edge6", n_pulse - p0, 1);
    edges(1);
    chk("ld4_edge7", n_pulse - p0, 2);
    edges(5);
    chk("ld4_edge12", n_pulse - p0, 3);

    // N=1 through a disabled load.
    set_en(0);
    load(0);
    set_en(1);
    chk("n1_active", int'(div_active), 0);
    p0 = n_pulse;
    edges(6);
    chk("n1_pulses", n_pulse - p0, 6);
    chk("n1_square", int'(square_out), int'(m_sq));

    // N=3 with disabled edges in the middle.
    set_en(0);
    load(2);
    set_en(1);
    p0 = n_pulse;
    edges(1);
    set_en(0);
    edges(3);
    set_en(1);
    edges(1);
    chk("dis_no_early", n_pulse - p0, 0);
    edges(1);
    chk("dis_third_en", n_pulse - p0, 1);

    // Two loads before the boundary: last wins, one ack.
    a0 = n_ack;
    load(5);
    load(1);
    edges(3);
    chk("dbl_acks", n_ack - a0, 1);
    chk("dbl_active", int'(div_active), 1);

    // Load coincident with the terminal edge.
    p0 = n_pulse;
    edges(1);
    do_edge(1, 3);
    chk("coin_strobe", n_pulse - p0, 1);
    chk("coin_active", int'(div_active), 3);

    // Largest ratio: N = 2^DIV_W.
    set_en(0);
    load(255);
    set_en(1);
    p0 = n_pulse;
    edges(255);
    chk("max_no_early", n_pulse - p0, 0);
    edges(1);
    chk("max_strobe", n_pulse - p0, 1);

    // Reset mid-period.
    edges(1);
    reset_pulse(1);
    p0 = n_pulse;
    edges(1);
    chk("rst_edge1", n_pulse - p0, 0);
    edges(1);
    chk("rst_edge2", n_pulse - p0, 1);

    // Randomized mix.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5)      do_edge(0, 0);
      else if (r == 6) do_edge(1, $urandom_range(0, 6));
      else if (r == 7) load($urandom_range(0, 6));
      else             set_en(!enable);
    end

    repeat (8) @(negedge clk);
    chk("pulse_queue_empty", pq.size(), 0);
    chk("ack_queue_empty", aq.size(), 0);
    chk("final_active", int'(div_active), m_act);
    chk("final_square", int'(square_out), int'(m_sq));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
